// File: rtl/fifo_sync_pkg.sv
// Shared defaults, depth helper and pointer/count typedefs for fifo_sync.
package fifo_sync_pkg;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;

  typedef logic [DEF_ASIZE:0] ptr_t;
  typedef logic [DEF_ASIZE:0] cnt_t;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// Simple dual-port RAM for fifo_sync; the read port is combinational when
// FIFO_SYNC_FWFT_EN is defined and a registered (1-cycle) port otherwise.
module fifo_sync_mem
  import fifo_sync_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is always on the output; reset and read-enable have no role here.
  logic unused_fwft;
  assign unused_fwft = rst ^ re;
  assign rdata       = mem_q[raddr];
`else
  logic [DSIZE-1:0] rdata_q;
  logic [DSIZE-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags
// and synchronous flush. Define FIFO_SYNC_FWFT_EN for first-word fall-through.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic [ASIZE:0]   count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH    = fifo_depth(ASIZE);
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_afull_range
    $error("fifo_sync: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_aempty_range
    $error("fifo_sync: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, DEPTH - 1);
  end

  logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic wfull_q, wfull_d, rempty_q, rempty_d;
  logic afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic wr_acc, rd_acc, mem_we, mem_re;

  always_comb begin
    wr_acc  = winc & ~wfull_q;
    rd_acc  = rinc & ~rempty_q;
    mem_we  = wr_acc & ~clr;
    mem_re  = rd_acc & ~clr;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      wptr_d  = wptr_q + (ASIZE+1)'(wr_acc);
      rptr_d  = rptr_q + (ASIZE+1)'(rd_acc);
      count_d = count_q + (ASIZE+1)'(wr_acc) - (ASIZE+1)'(rd_acc);
      ovf_d   = ovf_q | (winc & wfull_q);
      udf_d   = udf_q | (rinc & rempty_q);
    end
    // Flags follow the next occupancy so they are valid right after the edge.
    wfull_d  = (count_d == DEPTH_C);
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Pointer MSBs only carry the wrap; occupancy is tracked by count_q.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wptr_q[ASIZE] ^ rptr_q[ASIZE];

  fifo_sync_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .re    (mem_re),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (rdata)
  );

  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Randomised and directed bench for fifo_sync against a queue-based model;
// honours FIFO_SYNC_FWFT_EN for the read-data expectation.
module tb_fifo_sync;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst, clr, winc, rinc;
  logic [7:0] wdata, rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] mq[$];
  logic       m_ovf, m_udf;
  logic [7:0] m_rdata;

  fifo_sync #(.DSIZE(8), .ASIZE(4), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .wdata        (wdata),
    .winc         (winc),
    .wfull        (wfull),
    .rinc         (rinc),
    .rdata        (rdata),
    .rempty       (rempty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    check("count", 32'(count), n);
    check("wfull", wfull, n == DEPTH);
    check("rempty", rempty, n == 0);
    check("almost_full", almost_full, n >= AF);
    check("almost_empty", almost_empty, n <= AE);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_udf);
`ifdef FIFO_SYNC_FWFT_EN
    if (n > 0) check("rdata", rdata, mq[0]);
`else
    check("rdata", rdata, m_rdata);
`endif
  endtask

  // One clock: drive inputs, advance the model with the pre-edge occupancy, check.
  task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic c);
    bit full, empty;
    winc  = w;
    wdata = wd;
    rinc  = r;
    clr   = c;
    @(posedge clk);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (r && !empty) m_rdata = mq.pop_front();
      if (w && !full) mq.push_back(wd);
      if (w && full) m_ovf = 1'b1;
      if (r && empty) m_udf = 1'b1;
    end
    #1;
    check_all();
    $display("[TB] t=%0t w=%0b wd=%02h r=%0b c=%0b cnt=%0d rdata=%02h ovf=%0b udf=%0b",
             $time, w, wd, r, c, count, rdata, overflow, underflow);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Fill, overflow attempt, drain, underflow attempt
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming through the pointer wrap
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 120; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous ops at full, then at empty
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with a colliding write, then a clean write/read
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic: write-heavy then read-heavy, occasional flush
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i < 200) ? 70 : 30;
      step(($urandom_range(0, 99) < bias), 8'($urandom),
           ($urandom_range(0, 99) >= bias - 20), ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset in the middle of a period with 7 words stored
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    winc = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
